id_ex_stage: RTL

ID/EX pipeline stage that sits directly downstream of the opcode decoder. It registers the 11-bit decoded control word together with operands and register specifiers, and selects the destination register. It also detects load-use hazards against the instruction it holds, inserts bubbles, and honours downstream back-pressure and branch/jump flushes. The result is a clean, valid-qualified instruction bundle for the EX stage.

---
 rtl/id_ex_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, back-pressure hold and flush.
// Optional illegal-instruction trap (one-cycle exc_valid pulse, EXC_HOLD state) enabled by defining EXC_TRAP_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [10:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_wreg,
    output logic              stall_id,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_pc
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_EXC_HOLD = 1'b1;

    // Control bits that carry architectural side effects: jump, branch,
    // mem_to_reg, mem_write, mem_read and reg_write.
    localparam logic [10:0] SIDE_EFFECT_MASK = 11'h7C2;

    logic              ex_valid_q,   ex_valid_d;
    logic [10:0]       ex_ctrl_q,    ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc_q,      ex_pc_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [REG_W-1:0]  ex_rs_q,      ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q,      ex_rt_d;
    logic [REG_W-1:0]  ex_wreg_q,    ex_wreg_d;
    logic [0:0]        state_q,      state_d;

    logic              uses_rt;
    logic              rs_match;
    logic              rt_match;
    logic              hazard;
    logic              exc_hold;
    logic              trap_take;
    logic [10:0]       ctrl_in;
    logic [REG_W-1:0]  wreg_in;

`ifdef EXC_TRAP_EN
    logic              exc_valid_q, exc_valid_d;
    logic [DATA_W-1:0] exc_pc_q,    exc_pc_d;
`endif

    // Load-use detection against the bundle currently held for EX.
    always_comb begin
        uses_rt  = id_ctrl[0] | id_ctrl[7] | id_ctrl[9];
        rs_match = (id_rs == ex_wreg_q);
        rt_match = uses_rt & (id_rt == ex_wreg_q);
        hazard   = ex_valid_q & ex_ctrl_q[6] & (ex_wreg_q != '0) & id_valid
                   & (rs_match | rt_match);
        exc_hold = (state_q == ST_EXC_HOLD);
        stall_id = !flush & (hazard | !ex_ready | exc_hold);
    end

    // Sanitise the incoming control word and pick the destination register.
    always_comb begin
        ctrl_in   = id_ctrl;
        trap_take = 1'b0;
`ifdef EXC_TRAP_EN
        trap_take = id_valid & id_ctrl[3];
        if (trap_take) begin
            ctrl_in = id_ctrl & ~SIDE_EFFECT_MASK;
        end
`endif
        if (ctrl_in[1]) begin
            wreg_in = ctrl_in[0] ? id_rd : id_rt;
        end else begin
            wreg_in = '0;
        end
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_pc_d      = ex_pc_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_wreg_d    = ex_wreg_q;
        state_d      = state_q;
`ifdef EXC_TRAP_EN
        exc_valid_d  = 1'b0;
        exc_pc_d     = exc_pc_q;
`endif
        if (flush) begin
            ex_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else if (!ex_ready) begin
            ex_valid_d = ex_valid_q;
        end else if (exc_hold) begin
            // EX has taken the trapped bundle; nothing new enters until flush.
            ex_valid_d = 1'b0;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d   = id_valid;
            ex_ctrl_d    = ctrl_in;
            ex_pc_d      = id_pc;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_wreg_d    = wreg_in;
            if (trap_take) begin
                state_d = ST_EXC_HOLD;
            end
`ifdef EXC_TRAP_EN
            if (trap_take) begin
                exc_valid_d = 1'b1;
                exc_pc_d    = id_pc;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_wreg_q    <= '0;
            state_q      <= ST_RUN;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_wreg_q    <= ex_wreg_d;
            state_q      <= state_d;
        end
    end

`ifdef EXC_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
        end else begin
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_pc    = exc_pc_q;
`else
    assign exc_valid = 1'b0;
    assign exc_pc    = '0;
`endif

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_wreg    = ex_wreg_q;

endmodule
